// File: rtl/nonce_result_tx_if.sv
// Byte-stream link from the nonce result transmitter to the host-side interface.
// A byte moves on any rising edge where tx_valid && tx_ready; tx_data is held while valid and not ready.
interface nonce_result_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/nonce_result_tx.sv
// Frames a found nonce (SOF, job_id, nonce MSB first) and streams it byte by byte to the host.
// Optional trailing XOR checksum byte is enabled with NONCE_RESULT_TX_CHECKSUM_EN.
module nonce_result_tx #(
    parameter logic [7:0] SOF_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   send_data,
    input  logic [31:0]            nonce,
    input  logic [7:0]             job_id,
    nonce_result_tx_if.master      tx,
    output logic                   busy,
    output logic                   result_done,
    output logic [7:0]             drop_count,
    output logic [1:0]             state_dbg
);

`ifdef NONCE_RESULT_TX_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 7;
`else
    localparam int unsigned FRAME_LEN = 6;
`endif
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DONE  = 2'd2,
        ST_REARM = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] nonce_sh_q, nonce_sh_d;
    logic [7:0]  job_sh_q, job_sh_d;
    logic        send_q;
    logic [7:0]  drop_q, drop_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] job,
                                              input logic [31:0] n);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0: b = SOF_BYTE;
            3'd1: b = job;
            3'd2: b = n[31:24];
            3'd3: b = n[23:16];
            3'd4: b = n[15:8];
            3'd5: b = n[7:0];
`ifdef NONCE_RESULT_TX_CHECKSUM_EN
            3'd6: b = job ^ n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        nonce_sh_d = nonce_sh_q;
        job_sh_d   = job_sh_q;
        case (state_q)
            ST_IDLE: begin
                if (send_data) begin
                    nonce_sh_d = nonce;
                    job_sh_d   = job_id;
                    idx_d      = 3'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx.tx_ready) begin
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            ST_DONE:  state_d = ST_REARM;
            ST_REARM: if (!send_data) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so tx_ready never reaches tx_valid combinationally.
        tx_valid_d = (state_d == ST_SEND);
        tx_data_d  = (state_d == ST_SEND) ? frame_byte(idx_d, job_sh_d, nonce_sh_d) : 8'h00;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);

        // A rising send_data outside IDLE is a result we cannot take.
        drop_d = drop_q;
        if (send_data && !send_q && (state_q != ST_IDLE) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            nonce_sh_q <= 32'h0;
            job_sh_q   <= 8'h00;
            send_q     <= 1'b0;
            drop_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nonce_sh_q <= nonce_sh_d;
            job_sh_q   <= job_sh_d;
            send_q     <= send_data;
            drop_q     <= drop_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign busy        = busy_q;
    assign result_done = done_q;
    assign drop_count  = drop_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_nonce_result_tx.sv
// Bench for nonce_result_tx: table-driven frames, directed corner cases, and a random phase
// checked by a transaction-level model of the frame/drop rules.
module tb_nonce_result_tx;

`ifdef NONCE_RESULT_TX_CHECKSUM_EN
    localparam int N = 7;
`else
    localparam int N = 6;
`endif
    localparam logic [7:0] SOF = 8'hA5;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        send_data;
    logic [31:0] nonce;
    logic [7:0]  job_id;
    logic        busy, result_done;
    logic [7:0]  drop_count;
    logic [1:0]  state_dbg;

    nonce_result_tx_if bus();

    nonce_result_tx #(.SOF_BYTE(SOF)) dut (
        .clk(clk), .n_rst(n_rst), .send_data(send_data), .nonce(nonce), .job_id(job_id),
        .tx(bus), .busy(busy), .result_done(result_done), .drop_count(drop_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Model state: bytes still owed, DONE pulse owed, waiting for send_data to fall.
    int m_left = 0;
    bit m_done = 0;
    bit m_rearm = 0;
    bit m_prev_send = 0;
    int m_drops = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            m_left = 0; m_done = 0; m_rearm = 0; m_prev_send = 0; m_drops = 0;
            exp_q.delete();
        end else begin
            bit m_busy;
            bit rise;
            m_busy = (m_left > 0) || m_done || m_rearm;
            chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, m_left > 0});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("result_done", {31'b0, result_done}, {31'b0, m_done});
            chk("drop_count", {24'b0, drop_count}, 32'(m_drops));
            if (m_left > 0) begin
                if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
                else chk("tx_data", {24'b0, bus.tx_data}, {24'b0, exp_q[0]});
            end
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            if (result_done) done_cnt++;

            rise = send_data && !m_prev_send;
            m_prev_send = send_data;
            if (rise && m_busy && m_drops < 255) m_drops++;
            if (m_left > 0) begin
                if (bus.tx_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_left--;
                    if (m_left == 0) m_done = 1;
                end
            end else if (m_done) begin
                m_done = 0;
                m_rearm = 1;
            end else if (m_rearm) begin
                if (!send_data) m_rearm = 0;
            end else if (send_data) begin
                m_left = N;
                exp_q.push_back(SOF);
                exp_q.push_back(job_id);
                exp_q.push_back(nonce[31:24]);
                exp_q.push_back(nonce[23:16]);
                exp_q.push_back(nonce[15:8]);
                exp_q.push_back(nonce[7:0]);
`ifdef NONCE_RESULT_TX_CHECKSUM_EN
                exp_q.push_back(job_id ^ nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0]);
`endif
            end
        end
    end

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  job;
        int          stall_at;
        int          stall_len;
        bit          chg;
        int          exp_cyc;
        logic [7:0]  exp_b2;
        bit          gold;
    } vec_t;

    logic [7:0] gold_b [0:6];

    task automatic run_frame(input vec_t v, output int cyc);
        int acc, stalls;
        bit hit;
        @(posedge clk); #1;
        nonce = v.nonce; job_id = v.job; send_data = 1'b1; bus.tx_ready = 1'b1;
        got_q.delete();
        @(posedge clk); #1;
        send_data = 1'b0;
        if (v.chg) nonce = 32'hFFFFFFFF;
        cyc = 0; acc = 0; stalls = 0; hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (acc == v.stall_at && stalls < v.stall_len) begin
                bus.tx_ready = 1'b0;
                stalls++;
            end else begin
                bus.tx_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (bus.tx_valid && bus.tx_ready) acc++;
            if (result_done) hit = 1;
            else begin @(posedge clk); #1; end
        end
        if (!hit) chk("frame_timeout", 32'd0, 32'd1);
        bus.tx_ready = 1'b1;
    endtask

    task automatic check_gold(input string nm);
        chk({nm, "_len"}, 32'(got_q.size()), 32'(N));
        for (int i = 0; i < N; i++)
            if (i < got_q.size()) chk(nm, {24'b0, got_q[i]}, {24'b0, gold_b[i]});
    endtask

    task automatic wait_done(input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (result_done) hit = 1;
        end
        if (!hit) chk(nm, 32'd0, 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        int cyc, d0;

        gold_b[0] = 8'hA5; gold_b[1] = 8'h3C; gold_b[2] = 8'h12; gold_b[3] = 8'h34;
        gold_b[4] = 8'h56; gold_b[5] = 8'h78; gold_b[6] = 8'h34;
        vecs[0] = '{32'h12345678, 8'h3C, -1, 0, 1'b0, N + 1, 8'h12, 1'b1};
        vecs[1] = '{32'h12345678, 8'h3C,  2, 3, 1'b0, N + 4, 8'h12, 1'b1};
        vecs[2] = '{32'h12345678, 8'h3C, -1, 0, 1'b1, N + 1, 8'h12, 1'b1};
        vecs[3] = '{32'hDEADBEEF, 8'h00,  0, 1, 1'b0, N + 2, 8'hDE, 1'b0};
        vecs[4] = '{32'h00000000, 8'hFF, N - 1, 2, 1'b0, N + 3, 8'h00, 1'b0};

        n_rst = 1'b0; send_data = 1'b0; nonce = '0; job_id = '0; bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result_done", {31'b0, result_done}, 32'd0);
        chk("rst_drop_count", {24'b0, drop_count}, 32'd0);
        @(posedge clk); #1 n_rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            d0 = done_cnt;
            run_frame(vecs[k], cyc);
            chk($sformatf("v%0d_cycles", k), 32'(cyc), 32'(vecs[k].exp_cyc));
            if (got_q.size() > 2) chk($sformatf("v%0d_byte2", k), {24'b0, got_q[2]}, {24'b0, vecs[k].exp_b2});
            else chk($sformatf("v%0d_short", k), 32'(got_q.size()), 32'(N));
            if (vecs[k].gold) check_gold($sformatf("v%0d_gold", k));
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", k), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_done_pulses", k), 32'(done_cnt - d0), 32'd1);
        end

        // Held level: one frame only, no drops.
        d0 = done_cnt;
        @(posedge clk); #1;
        nonce = 32'h12345678; job_id = 8'h3C; send_data = 1'b1; bus.tx_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 send_data = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_frames", 32'(done_cnt - d0), 32'd1);
        chk("held_drops", {24'b0, drop_count}, 32'd0);
        chk("held_busy", {31'b0, busy}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 7) == 0) send_data = ~send_data;
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) nonce = $urandom;
            job_id = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1 send_data = 1'b0; bus.tx_ready = 1'b1;
        repeat (20) @(posedge clk);

        // Reset after the second byte is accepted.
        @(posedge clk); #1;
        nonce = 32'h12345678; job_id = 8'h3C; send_data = 1'b1; got_q.delete();
        @(posedge clk); #1 send_data = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 2; i++) @(negedge clk);
        chk("rst_mid_bytes", 32'(got_q.size()), 32'd2);
        @(posedge clk); #1 n_rst = 1'b0;
        #1;
        chk("rstmid_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("rstmid_tx_data", {24'b0, bus.tx_data}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_result_done", {31'b0, result_done}, 32'd0);
        chk("rstmid_drop_count", {24'b0, drop_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        run_frame(vecs[0], cyc);
        check_gold("after_rst");

        // Three drops during SEND, frame unchanged.
        repeat (3) @(posedge clk);
        #1;
        bus.tx_ready = 1'b0; nonce = 32'h12345678; job_id = 8'h3C; send_data = 1'b1;
        got_q.delete();
        @(posedge clk); #1;
        repeat (3) begin
            send_data = 1'b0;
            @(posedge clk); #1;
            send_data = 1'b1;
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b1; send_data = 1'b0;
        wait_done("ovf_timeout");
        chk("ovf_drops", {24'b0, drop_count}, 32'd3);
        check_gold("ovf_frame");

        // Saturation: 260 more drops.
        repeat (3) @(posedge clk);
        #1 bus.tx_ready = 1'b0; send_data = 1'b1;
        @(posedge clk); #1;
        repeat (260) begin
            send_data = 1'b0;
            @(posedge clk); #1;
            send_data = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sat_drops", {24'b0, drop_count}, 32'd255);
        @(posedge clk); #1 bus.tx_ready = 1'b1; send_data = 1'b0;
        wait_done("sat_timeout");
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nonce_result_tx.md
# nonce_result_tx

Byte-serial transmitter that carries a found nonce from the miner core back to the host. When the miner controller raises `send_data`, the block captures the current nonce and job ID, frames them, and streams the frame one byte at a time over a valid/ready link to the host-side interface. It is the outbound counterpart of the work-loading path that raises `data_ready` into the miner controller.

## Interface

Parameters:
- `SOF_BYTE`, default 8'hA5: start-of-frame marker, always the first byte of a frame.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `send_data`  in  1  level from the miner controller; high means a valid nonce is present on `nonce`.
- `nonce`  in  32  nonce to report; sampled only on the capture cycle.
- `job_id`  in  8  identifier of the work unit; sampled with `nonce`.
- `tx_ready`  in  1  host link can accept a byte this cycle.
- `tx_valid`  out  1  `tx_data` holds a frame byte.
- `tx_data`  out  8  current frame byte.
- `busy`  out  1  high in every state except IDLE.
- `result_done`  out  1  one-cycle pulse after the last byte of a frame is accepted.
- `drop_count`  out  8  results lost because `send_data` rose while busy; saturates at 255.

## Operation

- Frame, in order: `SOF_BYTE`, `job_id`, `nonce[31:24]`, `nonce[23:16]`, `nonce[15:8]`, `nonce[7:0]`, plus an optional checksum byte (see Configuration).
- A byte is transferred on any rising edge where `tx_valid && tx_ready`.
- States:
  - IDLE: `tx_valid`=0. If `send_data`=1, capture `nonce` and `job_id` into shadow registers, clear the byte index, and go to SEND.
  - SEND: `tx_valid`=1 and `tx_data`=frame[index].
    - On a handshake that is not the final byte: index+1.
    - On the final-byte handshake: go to DONE.
  - DONE: `result_done`=1 for exactly this cycle. Go to REARM.
  - REARM: `tx_valid`=0. Stay while `send_data`=1; go to IDLE when `send_data`=0. This prevents a held level from being reported twice.
- Drop detection: a registered copy of `send_data` provides a rising-edge detect.
  - A rising edge while the state is SEND, DONE, or REARM increments `drop_count`, saturating at 255.
  - A rising edge in IDLE is a normal capture and does not count.
- Shadow registers are the only frame source. Changes to `nonce` or `job_id` after capture do not affect the frame in flight.
- Reset values: state IDLE, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `result_done`=0, `drop_count`=0. Shadow registers and byte index reset to 0.

## Timing

- Capture edge k (IDLE, `send_data`=1): in cycle k+1, `tx_valid`=1 and `tx_data`=`SOF_BYTE`.
- `tx_data` must be stable while `tx_valid && !tx_ready`. Stalls of any length are allowed.
- With `tx_ready` held high, an N-byte frame occupies N consecutive SEND cycles. `result_done` follows in the next cycle.
- Minimum capture-to-capture spacing is N+3 cycles: SEND×N, DONE, REARM with `send_data` low, IDLE.
- `busy` is registered and rises in the cycle after capture.
- Reset asserted mid-frame clears everything asynchronously: `tx_valid` drops immediately and the partial frame is abandoned.
- The output valid/data path is registered; there is no combinational path from `tx_ready` to `tx_valid`.

## Configuration

- Macro: `NONCE_RESULT_TX_CHECKSUM_EN`.
- Defined:
  - A seventh byte is appended to the frame: the XOR of `job_id` and the four nonce bytes (SOF excluded).
  - N=7.
- Undefined:
  - The frame ends after `nonce[7:0]`.
  - N=6, and no checksum logic is present.

## Test plan

- Basic frame: `nonce`=32'h12345678, `job_id`=8'h3C, `tx_ready`=1, one capture.
  - Expect A5 3C 12 34 56 78 on consecutive cycles, then 34 when the checksum is enabled.
  - Expect a single `result_done` pulse and `busy` low after REARM once `send_data` falls.
- Backpressure: same stimulus with `tx_ready` low for 3 cycles on the third byte.
  - Expect `tx_data`=8'h12 held for all stalled cycles, no byte skipped or duplicated, and frame completion delayed by exactly 3 cycles.
- Held level: `send_data` high for 20 cycles.
  - Expect exactly one frame and `drop_count`=0.
- Overflow: `send_data` pulses low then high during SEND, three times.
  - Expect `drop_count`=3 and the frame content unchanged.
  - Separately, force 260 drops and expect `drop_count`=255.
- Reset mid-frame: assert `n_rst` low after the 2nd byte.
  - Expect `tx_valid`=0 immediately and all outputs at reset values.
  - After release with a new capture, expect the frame to start from `SOF_BYTE`.
- Input change after capture: change `nonce` to 32'hFFFFFFFF one cycle after capture.
  - Expect the frame still carries 32'h12345678.
